// File: rtl/dbchecker_pkg.sv
// Shared types and constants for the DBChecker debug-side blocks.
package dbchecker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int DBG_W       = 128;
    localparam int TRACE_WORDS = 9;
    localparam int TRACE_TSW   = 32;
    localparam int TRACE_EW    = TRACE_TSW + 2 * DBG_W;

endpackage

// File: rtl/dbchecker_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port, no reset.
module dbchecker_trace_ram
    import dbchecker_pkg::*;
#(
    parameter int  DEPTH = 256,
    parameter int  EW    = TRACE_EW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [EW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [EW-1:0] o_rdata
);

    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbchecker_trace_buf.sv
// Change-compressed, timestamped trace buffer for the DBChecker debug buses,
// with masked trigger, post-trigger count and a two-stage word readout.
module dbchecker_trace_buf
    import dbchecker_pkg::*;
#(
    parameter int  DEPTH = 256,
    parameter int  TSW   = TRACE_TSW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DBG_W-1:0] debug_if_flow,
    input  logic [DBG_W-1:0] debug_if_ctrl,
    input  logic             cfg_arm,
    input  logic             cfg_stop,
    input  logic [DBG_W-1:0] cfg_trig_mask,
    input  logic [DBG_W-1:0] cfg_trig_val,
    input  logic [AW:0]      cfg_post_cnt,
    output logic [1:0]       st_state,
    output logic [AW:0]      st_count,
    output logic             st_wrapped,
    output logic [AW-1:0]    st_trig_idx,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_idx,
    input  logic [3:0]       rd_word,
    output logic             rd_valid,
    output logic [31:0]      rd_data
);

    localparam int EW = TSW + 2 * DBG_W;

    trace_state_e     r_state;
    trace_state_e     w_state_nxt;
    logic             w_wr;
    logic             w_trig_hit;
    logic             w_trig;
    logic             w_change;

    logic [DBG_W-1:0] r_prev_flow;
    logic [DBG_W-1:0] r_prev_ctrl;
    logic [TSW-1:0]   r_ts;
    logic             r_first;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_wrapped;
    logic [AW:0]      r_post;
    logic [AW-1:0]    r_trig_phys;
    logic             r_trig_seen;
    logic             r_trig_lost;

    logic [AW-1:0]    w_base;
    logic [AW-1:0]    w_rd_addr;
    logic             w_rd_ok;
    logic [EW-1:0]    w_ram_q;
    logic [TSW-1:0]   w_q_ts;
    logic [DBG_W-1:0] w_q_flow;
    logic [DBG_W-1:0] w_q_ctrl;
    logic [1:0]       w_lane;
    logic [31:0]      w_word;

    logic             r_rd_v1;
    logic             r_rd_ok1;
    logic [3:0]       r_rd_word1;
    logic             r_rd_valid;
    logic [31:0]      r_rd_data;

    assign w_trig   = ((debug_if_ctrl & cfg_trig_mask) == cfg_trig_val);
    assign w_change = r_first
                    | (debug_if_flow != r_prev_flow)
                    | (debug_if_ctrl != r_prev_ctrl);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arm overrides everything, including a stop or trigger in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_trig_hit  = 1'b0;
        if (cfg_arm) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (cfg_stop) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_trig) begin
                        w_trig_hit  = 1'b1;
                        w_wr        = 1'b1;
                        w_state_nxt = (cfg_post_cnt == '0) ? ST_DONE : ST_POST;
                    end else if (w_change) begin
                        w_wr = 1'b1;
                    end
                end
                ST_POST: begin
                    if (cfg_stop) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_change) begin
                        w_wr = 1'b1;
                        if (r_post == (AW+1)'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev_flow <= '0;
            r_prev_ctrl <= '0;
            r_ts        <= '0;
            r_first     <= 1'b0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_post      <= '0;
            r_trig_phys <= '0;
            r_trig_seen <= 1'b0;
            r_trig_lost <= 1'b0;
        end else begin
            r_prev_flow <= debug_if_flow;
            r_prev_ctrl <= debug_if_ctrl;
            if (cfg_arm) begin
                r_ts        <= '0;
                r_first     <= 1'b1;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_wrapped   <= 1'b0;
                r_post      <= '0;
                r_trig_seen <= 1'b0;
                r_trig_lost <= 1'b0;
            end else begin
                r_ts    <= r_ts + TSW'(1);
                r_first <= 1'b0;
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    if (r_wr_ptr == '1) begin
                        r_wrapped <= 1'b1;
                    end
                    if (r_count != (AW+1)'(DEPTH)) begin
                        r_count <= r_count + (AW+1)'(1);
                    end
                    // A later write landing on the trigger slot means it was overwritten.
                    if (r_trig_seen && (r_wr_ptr == r_trig_phys)) begin
                        r_trig_lost <= 1'b1;
                    end
                end
                if (w_trig_hit) begin
                    r_trig_phys <= r_wr_ptr;
                    r_trig_seen <= 1'b1;
                    r_post      <= cfg_post_cnt;
                end else if (w_wr && (r_state == ST_POST)) begin
                    r_post <= r_post - (AW+1)'(1);
                end
            end
        end
    end

    dbchecker_trace_ram #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_ram (
        .i_clock (clock),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({r_ts, debug_if_flow, debug_if_ctrl}),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    assign w_base    = r_wrapped ? r_wr_ptr : '0;
    assign w_rd_addr = w_base + rd_idx;
    assign w_rd_ok   = (r_state == ST_DONE)
                     && ({1'b0, rd_idx} < r_count)
                     && (rd_word <= 4'(TRACE_WORDS - 1));

    assign w_q_ts   = w_ram_q[EW-1 -: TSW];
    assign w_q_flow = w_ram_q[2*DBG_W-1 -: DBG_W];
    assign w_q_ctrl = w_ram_q[DBG_W-1:0];
    // Words 1-4 and 5-8 share the same 32-bit lane pattern.
    assign w_lane   = 2'(r_rd_word1 - 4'd1);

    always_comb begin
        w_word = '0;
        if (r_rd_word1 == 4'd0) begin
            w_word = 32'(w_q_ts);
        end else if (r_rd_word1 <= 4'd4) begin
            w_word = w_q_flow[{w_lane, 5'b0} +: 32];
        end else begin
            w_word = w_q_ctrl[{w_lane, 5'b0} +: 32];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_v1    <= 1'b0;
            r_rd_ok1   <= 1'b0;
            r_rd_word1 <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= rd_req;
            r_rd_ok1   <= rd_req && w_rd_ok;
            r_rd_word1 <= rd_word;
            r_rd_valid <= r_rd_v1;
            r_rd_data  <= r_rd_ok1 ? w_word : '0;
        end
    end

    assign st_state    = r_state;
    assign st_count    = r_count;
    assign st_wrapped  = r_wrapped;
    assign st_trig_idx = (r_trig_seen && !r_trig_lost) ? (r_trig_phys - w_base) : '0;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;

endmodule
